// File: rtl/epb_wbm_sync_bridge.sv
// rtl/epb_wbm_sync_bridge.sv - single-clock EPB to Wishbone classic master bridge with watchdog and abort
// Optional posted writes are enabled with the macro EPB_WB_POSTED_WR_EN.
module epb_wbm_sync_bridge #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 25,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = '1,
  localparam int                   SEL_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  epb_cs_n,
  input  logic                  epb_oe_n,
  input  logic                  epb_r_w_n,
  input  logic [SEL_WIDTH-1:0]  epb_be_n,
  input  logic [ADDR_WIDTH-1:0] epb_addr,
  input  logic [DATA_WIDTH-1:0] epb_data_i,
  output logic [DATA_WIDTH-1:0] epb_data_o,
  output logic                  epb_data_oe_n,
  output logic                  epb_rdy,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  err_o,
  output logic                  timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RESP,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_prev_cs_n;
  logic                  r_cyc;
  logic                  r_we;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_abort;

  logic w_start;
  logic w_capture;
  logic w_in_wb;
  logic w_timeout;
  logic w_term;
  logic w_term_err;
  logic w_term_ack;
  logic w_term_to;
  logic w_skip_resp;
  logic w_upd_data;
  logic w_rdy_extra;

  assign w_in_wb    = (r_state == S_WB);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
  assign w_term_err = w_in_wb & wbm_err_i;
  assign w_term_ack = w_in_wb & ~wbm_err_i & wbm_ack_i;
  assign w_term_to  = w_in_wb & ~wbm_err_i & ~wbm_ack_i & w_timeout;
  assign w_term     = w_term_err | w_term_ack | w_term_to;

`ifdef EPB_WB_POSTED_WR_EN
  logic r_posted;
  logic r_pending;
  logic r_post_rdy;

  // A start seen during a posted write is replayed from the held EPB pins once the bus frees up.
  assign w_start     = (r_state == S_IDLE) & ~epb_cs_n & (r_prev_cs_n | r_pending);
  assign w_skip_resp = r_posted | r_abort | epb_cs_n;
  assign w_upd_data  = ~r_posted;
  assign w_rdy_extra = r_post_rdy;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_posted   <= 1'b0;
      r_pending  <= 1'b0;
      r_post_rdy <= 1'b0;
    end else begin
      r_post_rdy <= w_capture & ~epb_r_w_n;
      if (w_capture) begin
        r_posted <= ~epb_r_w_n;
      end
      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end else if (w_in_wb && r_posted && r_prev_cs_n && !epb_cs_n) begin
        r_pending <= 1'b1;
      end
    end
  end
`else
  assign w_start     = (r_state == S_IDLE) & r_prev_cs_n & ~epb_cs_n;
  assign w_skip_resp = r_abort | epb_cs_n;
  assign w_upd_data  = 1'b1;
  assign w_rdy_extra = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        if (w_term) begin
          w_state_nxt = w_skip_resp ? S_IDLE : S_RESP;
        end
      end
      S_RESP: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (epb_cs_n) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_prev_cs_n <= 1'b1;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_prev_cs_n <= epb_cs_n;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_capture) begin
        r_cyc   <= 1'b1;
        r_we    <= ~epb_r_w_n;
        r_sel   <= ~epb_be_n;
        r_adr   <= epb_addr;
        r_dat   <= epb_data_i;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (w_term) begin
        r_cyc <= 1'b0;
        if (w_term_err) begin
          r_err <= 1'b1;
          if (w_upd_data) begin
            r_rd_data <= ERR_DATA;
          end
        end else if (w_term_ack) begin
          if (!r_we) begin
            r_rd_data <= wbm_dat_i;
          end
        end else begin
          r_err     <= 1'b1;
          r_timeout <= 1'b1;
          if (w_upd_data) begin
            r_rd_data <= ERR_DATA;
          end
        end
      end else if (w_in_wb) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // Remember a release mid-cycle so the response phase is skipped even if cs_n drops again.
        if (epb_cs_n) begin
          r_abort <= 1'b1;
        end
      end
    end
  end

  assign wbm_cyc_o     = r_cyc;
  assign wbm_stb_o     = r_cyc;
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = r_sel;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;
  assign epb_data_o    = r_rd_data;
  assign err_o         = r_err;
  assign timeout_o     = r_timeout;
  assign epb_rdy       = (r_state == S_RESP) | w_rdy_extra;
  assign epb_data_oe_n = (!r_we && (r_state == S_RESP || r_state == S_HOLD)) ? epb_oe_n : 1'b1;

endmodule

// File: tb/tb_epb_wbm_sync_bridge.sv
// tb/tb_epb_wbm_sync_bridge.sv - directed self-checking bench for epb_wbm_sync_bridge
// Posted-write scenario runs only when EPB_WB_POSTED_WR_EN is defined.
module tb_epb_wbm_sync_bridge;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        oe_n;
  logic        r_w_n;
  logic [3:0]  be_n;
  logic [24:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        data_oe_n;
  logic        rdy;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [24:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        err_o;
  logic        to_o;

  int n_pass;
  int n_total;

  epb_wbm_sync_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (25),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .epb_cs_n     (cs_n),
    .epb_oe_n     (oe_n),
    .epb_r_w_n    (r_w_n),
    .epb_be_n     (be_n),
    .epb_addr     (addr),
    .epb_data_i   (data_i),
    .epb_data_o   (data_o),
    .epb_data_oe_n(data_oe_n),
    .epb_rdy      (rdy),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_sel_o    (sel),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack),
    .wbm_err_i    (err),
    .err_o        (err_o),
    .timeout_o    (to_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; cs_n = 1'b1; oe_n = 1'b1; r_w_n = 1'b1; be_n = 4'hF;
    addr = '0; data_i = '0; dat_i = '0; ack = 1'b0; err = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({cyc, stb, we, sel} !== 7'h00) $display("FAIL reset_wb_ctl: got %h expected 00", {cyc, stb, we, sel});
    else n_pass++;
    n_total++;
    if ({adr, dat_o} !== 57'h0) $display("FAIL reset_wb_adr_dat: got %h expected 0", {adr, dat_o});
    else n_pass++;
    n_total++;
    if (data_o !== 32'h0) $display("FAIL reset_data_o: got %h expected 00000000", data_o);
    else n_pass++;
    n_total++;
    if ({data_oe_n, rdy, err_o, to_o} !== 4'b1000) $display("FAIL reset_epb_flags: got %b expected 1000", {data_oe_n, rdy, err_o, to_o});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    cs_n = 1'b0; r_w_n = 1'b1; be_n = 4'h0; addr = 25'h10; oe_n = 1'b0;
    @(negedge clk);
    n_total++;
    if ({cyc, stb, we} !== 3'b110) $display("FAIL read_cyc_stb_we: got %b expected 110", {cyc, stb, we});
    else n_pass++;
    n_total++;
    if ({sel, adr} !== {4'hF, 25'h10}) $display("FAIL read_sel_adr: got %h/%h expected F/0000010", sel, adr);
    else n_pass++;
    n_total++;
    if ({data_oe_n, rdy} !== 2'b10) $display("FAIL read_wb_phase_epb: got %b expected 10", {data_oe_n, rdy});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (cyc !== 1'b1) $display("FAIL read_cyc_held: got %b expected 1", cyc);
    else n_pass++;
    ack = 1'b1; dat_i = 32'hCAFEF00D;
    @(negedge clk);
    ack = 1'b0; dat_i = '0;
    n_total++;
    if ({cyc, rdy, data_oe_n} !== 3'b010) $display("FAIL read_resp: got cyc/rdy/oe_n %b expected 010", {cyc, rdy, data_oe_n});
    else n_pass++;
    n_total++;
    if (data_o !== 32'hCAFEF00D) $display("FAIL read_data: got %h expected CAFEF00D", data_o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rdy, data_oe_n} !== 2'b00) $display("FAIL read_hold: got rdy/oe_n %b expected 00", {rdy, data_oe_n});
    else n_pass++;
    oe_n = 1'b1;
    #1;
    n_total++;
    if (data_oe_n !== 1'b1) $display("FAIL read_oe_follow: got %b expected 1", data_oe_n);
    else n_pass++;
    cs_n = 1'b1;
    @(negedge clk);
    oe_n = 1'b0;
    #1;
    n_total++;
    if (data_oe_n !== 1'b1) $display("FAIL read_oe_after_cs: got %b expected 1", data_oe_n);
    else n_pass++;
    oe_n = 1'b1;
  endtask

  task automatic test_write;
    @(negedge clk);
    cs_n = 1'b0; r_w_n = 1'b0; be_n = 4'hC; data_i = 32'h12345678; ack = 1'b1;
    @(negedge clk);
    n_total++;
    if ({cyc, we, sel, rdy} !== 7'b1_1_0011_0) $display("FAIL write_ctl: got %b expected 1100110", {cyc, we, sel, rdy});
    else n_pass++;
    n_total++;
    if (dat_o !== 32'h12345678) $display("FAIL write_dat: got %h expected 12345678", dat_o);
    else n_pass++;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if ({cyc, rdy, data_oe_n, err_o} !== 4'b0110) $display("FAIL write_resp: got cyc/rdy/oe_n/err %b expected 0110", {cyc, rdy, data_oe_n, err_o});
    else n_pass++;
    n_total++;
    if (data_o !== 32'hCAFEF00D) $display("FAIL write_data_o_kept: got %h expected CAFEF00D", data_o);
    else n_pass++;
    cs_n = 1'b1; r_w_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({rdy, data_oe_n} !== 2'b01) $display("FAIL write_hold: got %b expected 01", {rdy, data_oe_n});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_err_ack;
    @(negedge clk);
    cs_n = 1'b0; r_w_n = 1'b1; be_n = 4'h0; addr = 25'h44;
    @(negedge clk);
    ack = 1'b1; err = 1'b1; dat_i = 32'h11112222;
    @(negedge clk);
    ack = 1'b0; err = 1'b0;
    n_total++;
    if (data_o !== 32'hFFFFFFFF) $display("FAIL erracc_data: got %h expected FFFFFFFF", data_o);
    else n_pass++;
    n_total++;
    if ({cyc, rdy, err_o, to_o} !== 4'b0110) $display("FAIL erracc_flags: got cyc/rdy/err/to %b expected 0110", {cyc, rdy, err_o, to_o});
    else n_pass++;
    cs_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({err_o, to_o} !== 2'b00) $display("FAIL erracc_pulse_len: got %b expected 00", {err_o, to_o});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    @(negedge clk);
    cs_n = 1'b0; r_w_n = 1'b1; addr = 25'h80;
    @(negedge clk);
    n_total++;
    if (cyc !== 1'b1) $display("FAIL abort_cyc_start: got %b expected 1", cyc);
    else n_pass++;
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (cyc !== 1'b1) $display("FAIL abort_cyc_held: got %b expected 1", cyc);
    else n_pass++;
    @(negedge clk);
    ack = 1'b1; dat_i = 32'h5A5A5A5A;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if ({cyc, rdy} !== 2'b00) $display("FAIL abort_end: got cyc/rdy %b expected 00", {cyc, rdy});
    else n_pass++;
    n_total++;
    if (data_o !== 32'h5A5A5A5A) $display("FAIL abort_data: got %h expected 5A5A5A5A", data_o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL abort_no_rdy: got %b expected 0", rdy);
    else n_pass++;
    cs_n = 1'b0; addr = 25'h84;
    @(negedge clk);
    n_total++;
    if ({cyc, adr} !== {1'b1, 25'h84}) $display("FAIL abort_restart: got cyc %b adr %h expected 1 0000084", cyc, adr);
    else n_pass++;
    ack = 1'b1; dat_i = 32'h0BADBEEF;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if ({rdy, data_o} !== {1'b1, 32'h0BADBEEF}) $display("FAIL abort_restart_done: got rdy %b data %h expected 1 0BADBEEF", rdy, data_o);
    else n_pass++;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n_cyc, n_err, n_to, n_rdy;
    n_cyc = 0; n_err = 0; n_to = 0; n_rdy = 0;
    cs_n = 1'b0; r_w_n = 1'b1; addr = 25'h1FFFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc) n_cyc++;
      if (err_o) n_err++;
      if (to_o) n_to++;
      if (rdy) n_rdy++;
    end
    n_total++;
    if (n_cyc != 8) $display("FAIL timeout_cyc_len: got %0d expected 8", n_cyc);
    else n_pass++;
    n_total++;
    if (n_err != 1 || n_to != 1) $display("FAIL timeout_pulses: got err %0d to %0d expected 1 1", n_err, n_to);
    else n_pass++;
    n_total++;
    if (n_rdy != 1) $display("FAIL timeout_rdy: got %0d expected 1", n_rdy);
    else n_pass++;
    n_total++;
    if (data_o !== 32'hFFFFFFFF) $display("FAIL timeout_data: got %h expected FFFFFFFF", data_o);
    else n_pass++;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef EPB_WB_POSTED_WR_EN
  task automatic test_posted;
    cs_n = 1'b0; r_w_n = 1'b0; be_n = 4'h0; addr = 25'h100; data_i = 32'hA5A50001;
    @(negedge clk);
    n_total++;
    if ({rdy, cyc, we} !== 3'b111) $display("FAIL posted_early_rdy: got %b expected 111", {rdy, cyc, we});
    else n_pass++;
    cs_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL posted_rdy_len: got %b expected 0", rdy);
    else n_pass++;
    cs_n = 1'b0; r_w_n = 1'b1; addr = 25'h104;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({cyc, we, adr} !== {2'b11, 25'h100}) $display("FAIL posted_write_held: got %b %h expected 11 0000100", {cyc, we}, adr);
    else n_pass++;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if ({cyc, rdy} !== 2'b00) $display("FAIL posted_gap: got %b expected 00", {cyc, rdy});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({cyc, we, adr} !== {2'b10, 25'h104}) $display("FAIL posted_pending_read: got %b %h expected 10 0000104", {cyc, we}, adr);
    else n_pass++;
    ack = 1'b1; dat_i = 32'h600DF00D;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if ({rdy, data_o} !== {1'b1, 32'h600DF00D}) $display("FAIL posted_read_done: got rdy %b data %h expected 1 600DF00D", rdy, data_o);
    else n_pass++;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    cs_n = 1'b0; r_w_n = 1'b1; addr = 25'h200;
    @(negedge clk);
    n_total++;
    if (cyc !== 1'b1) $display("FAIL rstmid_pre: got %b expected 1", cyc);
    else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cyc, stb, we, sel} !== 7'h00) $display("FAIL rstmid_wb_ctl: got %h expected 00", {cyc, stb, we, sel});
    else n_pass++;
    n_total++;
    if ({adr, dat_o, data_o} !== 89'h0) $display("FAIL rstmid_regs: got %h expected 0", {adr, dat_o, data_o});
    else n_pass++;
    n_total++;
    if ({data_oe_n, rdy, err_o, to_o} !== 4'b1000) $display("FAIL rstmid_epb_flags: got %b expected 1000", {data_oe_n, rdy, err_o, to_o});
    else n_pass++;
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_read();
    test_write();
    test_err_ack();
    test_abort();
    test_timeout();
`ifdef EPB_WB_POSTED_WR_EN
    test_posted();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
